// File: rtl/uart_sniff_reporter.sv
// Return path of the UART sniffer: queues bytes captured from board 1 / board 2 and
// streams them to the PC as tag+data pairs, with '!'+count reports for lost bytes.
module uart_sniff_reporter #(
  parameter int FIFO_DEPTH = 16,
  parameter int FIFO_AW    = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               sniff_en,
  input  logic               b1_valid,
  input  logic [7:0]         b1_data,
  input  logic               b2_valid,
  input  logic [7:0]         b2_data,
  input  logic               tx_rdy,
  output logic               tx_en,
  output logic [7:0]         tx_data,
  output logic [FIFO_AW:0]   fifo_level,
  output logic [7:0]         drop_cnt
);

  // state     | meaning
  // IDLE      | wait for tx_rdy and a pending drop report or queued entry
  // SEND_TAG  | offer tag byte (21 / 31 / 32)
  // GAP_TAG   | one idle cycle after the tag
  // SEND_DATA | offer data byte (head entry or drop snapshot)
  // GAP_DATA  | one idle cycle after the data byte
  localparam logic [2:0] IDLE      = 3'd0;
  localparam logic [2:0] SEND_TAG  = 3'd1;
  localparam logic [2:0] GAP_TAG   = 3'd2;
  localparam logic [2:0] SEND_DATA = 3'd3;
  localparam logic [2:0] GAP_DATA  = 3'd4;

  localparam logic [FIFO_AW:0] DEPTH_L = (FIFO_AW + 1)'(FIFO_DEPTH);

  logic [2:0]         state;
  logic [8:0]         mem [FIFO_DEPTH];
  logic [FIFO_AW-1:0] wptr, rptr;
  logic [FIFO_AW:0]   free;
  logic               w1, w2, wr_a, wr_b, pop;
  logic [8:0]         ent_a, ent_b;
  logic [1:0]         nwr, ndrop;
  logic               start_drop, start_fifo, is_drop;
  logic [7:0]         tag_q, snap_q, last_q, cur_byte, drop_base;
  logic [8:0]         drop_sum;

  always_comb begin
    w1    = sniff_en & b1_valid;
    w2    = sniff_en & b2_valid;
    free  = DEPTH_L - fifo_level;
    wr_a  = 1'b0;
    wr_b  = 1'b0;
    ent_a = {1'b0, b1_data};
    ent_b = {1'b1, b2_data};
    nwr   = 2'd0;
    ndrop = 2'd0;
    // Space is judged before any same-cycle pop; B1 always takes the first slot.
    if (w1 && w2) begin
      if (free >= 2) begin
        wr_a = 1'b1;
        wr_b = 1'b1;
        nwr  = 2'd2;
      end else if (free == 1) begin
        wr_a  = 1'b1;
        nwr   = 2'd1;
        ndrop = 2'd1;
      end else begin
        ndrop = 2'd2;
      end
    end else if (w1 || w2) begin
      ent_a = w1 ? {1'b0, b1_data} : {1'b1, b2_data};
      if (free != 0) begin
        wr_a = 1'b1;
        nwr  = 2'd1;
      end else begin
        ndrop = 2'd1;
      end
    end

    start_drop = (state == IDLE) && tx_rdy && (drop_cnt != 8'd0);
    start_fifo = (state == IDLE) && tx_rdy && (drop_cnt == 8'd0) && (fifo_level != 0);
    tx_en      = ((state == SEND_TAG) || (state == SEND_DATA)) && tx_rdy;
    cur_byte   = (state == SEND_TAG) ? tag_q : (is_drop ? snap_q : mem[rptr][7:0]);
    tx_data    = tx_en ? cur_byte : last_q;
    pop        = (state == SEND_DATA) && tx_en && !is_drop;
    // Drops landing in the snapshot cycle count into the freshly cleared counter.
    drop_base  = start_drop ? 8'd0 : drop_cnt;
    drop_sum   = {1'b0, drop_base} + {7'd0, ndrop};
  end

  always_ff @(posedge clk) begin
    if (wr_a) mem[wptr] <= ent_a;
    if (wr_b) mem[wptr + FIFO_AW'(1)] <= ent_b;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      wptr       <= '0;
      rptr       <= '0;
      fifo_level <= '0;
      drop_cnt   <= 8'd0;
      tag_q      <= 8'd0;
      snap_q     <= 8'd0;
      last_q     <= 8'd0;
      is_drop    <= 1'b0;
    end else begin
      wptr       <= wptr + FIFO_AW'(nwr);
      rptr       <= rptr + FIFO_AW'(pop);
      fifo_level <= fifo_level + (FIFO_AW + 1)'(nwr) - (FIFO_AW + 1)'(pop);
      drop_cnt   <= drop_sum[8] ? 8'hFF : drop_sum[7:0];
      if (tx_en) last_q <= cur_byte;
      case (state)
        IDLE: begin
          if (start_drop) begin
            snap_q  <= drop_cnt;
            is_drop <= 1'b1;
            tag_q   <= 8'h21;
            state   <= SEND_TAG;
          end else if (start_fifo) begin
            is_drop <= 1'b0;
            tag_q   <= mem[rptr][8] ? 8'h32 : 8'h31;
            state   <= SEND_TAG;
          end
        end
        SEND_TAG:  if (tx_en) state <= GAP_TAG;
        GAP_TAG:   state <= SEND_DATA;
        SEND_DATA: if (tx_en) state <= GAP_DATA;
        GAP_DATA:  state <= IDLE;
        default:   state <= IDLE;
      endcase
    end
  end

endmodule
